// File: rtl/seq_detect_moore_if.sv
// Serial-bit bus for seq_detect_moore: qualified data in, clear, and the
// registered match flag, debug state and match counter out.
interface seq_detect_moore_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned SW = $clog2(PAT_LEN + 1);

  logic             din_valid;
  logic             din;
  logic             clr;
  logic             dout;
  logic [SW-1:0]    state_o;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output din_valid, din, clr,
    input  dout, state_o, match_cnt
  );

  modport slave (
    input  din_valid, din, clr,
    output dout, state_o, match_cnt
  );
endinterface

// File: rtl/seq_detect_moore.sv
// Parametrised Moore serial pattern detector with a KMP transition table built
// at elaboration. Define SEQ_DET_MATCH_CNT_EN to enable the saturating match counter.
module seq_detect_moore #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input logic                clk,
  input logic                areset_n,
  seq_detect_moore_if.slave  bus
);
  localparam int unsigned   SW    = $clog2(PAT_LEN + 1);
  localparam logic [SW-1:0] MATCH = SW'(PAT_LEN);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
    $fatal(1, "seq_detect_moore: PAT_LEN must be in 2..16");
  end

  // Next state from s matched bits plus bit b: longest suffix of
  // (prefix_s ++ b), at most PAT_LEN long, that is also a pattern prefix.
  // Capping at PAT_LEN makes s == PAT_LEN the overlapping failure rule.
  function automatic logic [SW-1:0] delta(input int unsigned s, input logic b);
    logic [31:0] pat32;
    logic [31:0] str;
    logic [31:0] mask;
    logic [31:0] pfx;
    int unsigned best;
    pat32 = 32'(PATTERN);
    str   = ((pat32 >> (PAT_LEN - s)) << 1) | 32'(b);
    best  = 0;
    for (int unsigned k = 1; k <= PAT_LEN; k++) begin
      if (k <= s + 1) begin
        mask = (32'd1 << k) - 32'd1;
        pfx  = pat32 >> (PAT_LEN - k);
        if ((str & mask) == pfx) best = k;
      end
    end
    return SW'(best);
  endfunction

  logic [SW-1:0] nxt_tab [PAT_LEN+1][2];

  for (genvar s = 0; s <= PAT_LEN; s++) begin : g_row
    localparam int unsigned SRC = (s == PAT_LEN && OVERLAP == 1'b0) ? 0 : s;
    assign nxt_tab[s][0] = delta(SRC, 1'b0);
    assign nxt_tab[s][1] = delta(SRC, 1'b1);
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= '0;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clr)            state_nxt = '0;
    else if (bus.din_valid) state_nxt = nxt_tab[state][bus.din];
  end

  assign bus.dout    = (state == MATCH);
  assign bus.state_o = state;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic             hit;

  // Every valid bit that lands in the match state is a new match, including
  // match-to-match steps of self-overlapping patterns; holds do not count.
  assign hit = !bus.clr && bus.din_valid && (state_nxt == MATCH);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)              cnt <= '0;
    else if (bus.clr)           cnt <= '0;
    else if (hit && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

  assign bus.match_cnt = cnt;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_seq_detect_moore.sv
// Randomised bench for seq_detect_moore: four parameter variants share one
// stimulus stream and are compared every cycle against a history-based model.
`timescale 1ns/1ps
module tb_seq_detect_moore;
  localparam int NI = 4;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic areset_n;
  logic clr;
  logic din_valid;
  logic din;

  int checks = 0;
  int errors = 0;

  // Variants: A overlap, B non-overlap, C overlap with 2-bit counter, D 6-bit pattern.
  int          plen [NI] = '{4, 4, 4, 6};
  logic [15:0] pat  [NI] = '{16'b1101, 16'b1101, 16'b1101, 16'b110110};
  bit          ovl  [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cwid [NI] = '{8, 8, 2, 8};

  seq_detect_moore_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
  seq_detect_moore_if #(.PAT_LEN(4), .CNT_W(8)) if_b ();
  seq_detect_moore_if #(.PAT_LEN(4), .CNT_W(2)) if_c ();
  seq_detect_moore_if #(.PAT_LEN(6), .CNT_W(8)) if_d ();

  assign if_a.din_valid = din_valid; assign if_a.din = din; assign if_a.clr = clr;
  assign if_b.din_valid = din_valid; assign if_b.din = din; assign if_b.clr = clr;
  assign if_c.din_valid = din_valid; assign if_c.din = din; assign if_c.clr = clr;
  assign if_d.din_valid = din_valid; assign if_d.din = din; assign if_d.clr = clr;

  seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8))
    u_a (.clk(clk), .areset_n(areset_n), .bus(if_a));
  seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8))
    u_b (.clk(clk), .areset_n(areset_n), .bus(if_b));
  seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2))
    u_c (.clk(clk), .areset_n(areset_n), .bus(if_c));
  seq_detect_moore #(.PAT_LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(8))
    u_d (.clk(clk), .areset_n(areset_n), .bus(if_d));

  logic dd [NI];
  int   ds [NI];
  int   dc [NI];
  assign dd[0] = if_a.dout; assign ds[0] = int'(if_a.state_o); assign dc[0] = int'(if_a.match_cnt);
  assign dd[1] = if_b.dout; assign ds[1] = int'(if_b.state_o); assign dc[1] = int'(if_b.match_cnt);
  assign dd[2] = if_c.dout; assign ds[2] = int'(if_c.state_o); assign dc[2] = int'(if_c.match_cnt);
  assign dd[3] = if_d.dout; assign ds[3] = int'(if_d.state_o); assign dc[3] = int'(if_d.match_cnt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: keep the last PAT_LEN accepted bits; the state is the longest tail
  // of that history which equals the start of the pattern.
  bit hist [NI][16];
  int hlen [NI] = '{0, 0, 0, 0};
  int ms   [NI] = '{0, 0, 0, 0};
  int mc   [NI] = '{0, 0, 0, 0};

  function automatic bit pbit(input int n, input int i);
    logic [15:0] p;
    int idx;
    p   = pat[n];
    idx = plen[n] - 1 - i;
    return p[idx[3:0]];
  endfunction

  function automatic int longest(input int n);
    int best = 0;
    for (int k = 1; k <= hlen[n]; k++) begin
      bit ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (hist[n][hlen[n] - k + i] != pbit(n, i)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic model_step();
    for (int n = 0; n < NI; n++) begin
      if (!areset_n || clr) begin
        hlen[n] = 0; ms[n] = 0; mc[n] = 0;
      end else if (din_valid) begin
        if (!ovl[n] && ms[n] == plen[n]) hlen[n] = 0;
        if (hlen[n] < plen[n]) begin
          hist[n][hlen[n]] = din;
          hlen[n]++;
        end else begin
          for (int i = 0; i < plen[n] - 1; i++) hist[n][i] = hist[n][i + 1];
          hist[n][plen[n] - 1] = din;
        end
        ms[n] = longest(n);
        if (ms[n] == plen[n] && mc[n] < (1 << cwid[n]) - 1) mc[n]++;
      end
    end
  endtask

  always @(posedge clk or negedge areset_n) model_step();

  always @(negedge clk) begin
    for (int n = 0; n < NI; n++) begin
      int ec;
      ec = CNT_EN ? mc[n] : 0;
      checks += 3;
      if (ds[n] != ms[n]) begin
        errors++;
        $display("FAIL state[%0d] t=%0t: got %0d expected %0d", n, $time, ds[n], ms[n]);
      end
      if (int'(dd[n]) != int'(ms[n] == plen[n])) begin
        errors++;
        $display("FAIL dout[%0d] t=%0t: got %0d expected %0d", n, $time, dd[n], ms[n] == plen[n]);
      end
      if (dc[n] != ec) begin
        errors++;
        $display("FAIL match_cnt[%0d] t=%0t: got %0d expected %0d", n, $time, dc[n], ec);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #2;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    drive(1'b0, 1'b0);
    clr = 1'b0;
  endtask

  initial begin
    bit b1 [4] = '{1, 1, 0, 1};
    int e1 [4] = '{1, 2, 3, 4};
    bit b2 [7] = '{1, 1, 0, 1, 1, 0, 1};
    int e2a[7] = '{1, 2, 3, 4, 2, 3, 4};
    int e2b[7] = '{1, 2, 3, 4, 1, 0, 1};
    bit b3 [5] = '{1, 1, 1, 0, 1};
    int e3 [5] = '{1, 2, 2, 3, 4};
    bit b6 [3] = '{1, 0, 1};

    areset_n = 1'b0; clr = 1'b0; din_valid = 1'b0; din = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    lit("rst_state", ds[0], 0);
    lit("rst_dout", int'(dd[0]), 0);
    lit("rst_cnt", dc[0], 0);
    areset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b1[i]);
      lit("t1_state", ds[0], e1[i]);
      lit("t1_dout", int'(dd[0]), (i == 3) ? 1 : 0);
    end
    lit("t1_cnt", dc[0], CNT_EN ? 1 : 0);

    do_clr();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, b2[i]);
      lit("t2_state_ovl", ds[0], e2a[i]);
      lit("t2_state_novl", ds[1], e2b[i]);
      lit("t2_dout_ovl", int'(dd[0]), (i == 3 || i == 6) ? 1 : 0);
      lit("t2_dout_novl", int'(dd[1]), (i == 3) ? 1 : 0);
    end
    lit("t2_cnt_ovl", dc[0], CNT_EN ? 2 : 0);
    lit("t2_cnt_novl", dc[1], CNT_EN ? 1 : 0);

    do_clr();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, b3[i]);
      lit("t3_state", ds[0], e3[i]);
      lit("t3_dout", int'(dd[0]), (i == 4) ? 1 : 0);
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0]);
      lit("t4_hold_state", ds[0], 4);
      lit("t4_hold_dout", int'(dd[0]), 1);
      lit("t4_hold_cnt", dc[0], CNT_EN ? 1 : 0);
    end
    drive(1'b1, 1'b0);
    lit("t4_exit_state", ds[0], 0);
    lit("t4_exit_dout", int'(dd[0]), 0);

    do_clr();
    drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    lit("t5_pre_state", ds[0], 3);
    #1 areset_n = 1'b0;
    #1;
    lit("t5_async_state", ds[0], 0);
    lit("t5_async_dout", int'(dd[0]), 0);
    lit("t5_async_state_novl", ds[1], 0);
    areset_n = 1'b1;
    drive(1'b1, 1'b1);
    lit("t5_after_state", ds[0], 1);
    lit("t5_after_dout", int'(dd[0]), 0);

    do_clr();
    for (int i = 0; i < 4; i++) drive(1'b1, b1[i]);
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 3; i++) drive(1'b1, b6[i]);
    lit("t6_sat_cnt", dc[2], CNT_EN ? 3 : 0);
    lit("t6_wide_cnt", dc[0], CNT_EN ? 5 : 0);
    drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    lit("t6_pre_state", ds[2], 3);
    clr = 1'b1;
    drive(1'b1, 1'b1);
    clr = 1'b0;
    lit("t6_clr_state", ds[2], 0);
    lit("t6_clr_cnt", dc[2], 0);
    lit("t6_clr_dout", int'(dd[2]), 0);

    for (int c = 0; c < 4000; c++) begin
      clr = ($urandom_range(0, 63) == 0);
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 499) == 0) begin
        #1 areset_n = 1'b0;
        #1 areset_n = 1'b1;
      end
    end
    clr = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detect_moore.md
Name: seq_detect_moore

Overview:
- Parametrised Moore-style serial pattern detector.
- Successor to the fixed 4-state din/dout FSM: the pattern, its length and the overlap mode are now parameters, and the block adds input qualification and a synchronous clear.
- Sits on a 1-bit serial data path; flags completion of a programmed bit pattern with a registered, state-decoded output.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, pattern bits; PATTERN[PAT_LEN-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = detector restarts from empty after each match.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- areset_n  in  1  asynchronous active-low reset.
- din_valid  in  1  din is sampled only when this is 1.
- din  in  1  serial data bit.
- clr  in  1  synchronous clear of state and counter.
- dout  out  1  1 while the FSM is in the match state.
- state_o  out  clog2(PAT_LEN+1)  current state, for debug.
- match_cnt  out  CNT_W  saturating match count; see Optional Feature.

Behaviour:
- Reset and state encoding:
  - State S = number of pattern prefix bits currently matched, 0..PAT_LEN.
  - S = PAT_LEN is the match state.
  - Reset: areset_n low forces S = 0, dout = 0 and match_cnt = 0 immediately, without waiting for a clock.
  - Release of reset is synchronous to clk.
- Output:
  - dout = (S == PAT_LEN), decoded from registered state only.
  - No combinational path from din or din_valid to dout.
- Latency:
  - dout rises on the clk edge that samples the last pattern bit.
  - It is visible for the cycle after that edge.
- Qualification:
  - din_valid = 0: S holds, including when S = PAT_LEN, so dout stays high until the next valid bit.
  - din_valid = 1: S advances per the transition rule below.
- Transition rule, from S < PAT_LEN with bit b:
  - If b == pattern bit S, then next S = S+1.
  - Otherwise next S = length of the longest proper suffix of (matched prefix ++ b) that is also a prefix of the pattern.
  - This is the KMP failure rule: a mismatch never discards a partial match still in progress.
- Transition rule, from S = PAT_LEN:
  - OVERLAP = 1: apply the failure rule to the full pattern, then extend with b.
  - OVERLAP = 0: treat as S = 0 and apply b.
- The transition table is computed at elaboration from PATTERN and PAT_LEN. No runtime pattern logic.
- clr:
  - clr = 1 at a clk edge gives next S = 0 and match_cnt = 0.
  - clr has priority over din_valid.
- Priority order: areset_n, then clr, then din_valid.
- A reset or clr arriving mid-pattern discards any partial match; the next match needs a complete fresh pattern.
- Illegal parameters: PAT_LEN outside 2..16 is a fatal elaboration error.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on each clk edge where S transitions into PAT_LEN from any state.
  - Holding in PAT_LEN (din_valid = 0) does not increment it.
  - It saturates at 2^CNT_W-1.
  - It is cleared by clr and by reset.
- Not defined:
  - match_cnt is tied to 0.
  - No counter flops are instantiated.
- dout behaviour is identical in both builds.

Test Plan (PAT_LEN=4, PATTERN=4'b1101, CNT_W=8, din_valid=1 unless stated):
1. Basic match, OVERLAP=1: din 1,1,0,1 → dout 0,0,0,1 after each edge; state_o 1,2,3,4; match_cnt=1 with the macro.
2. Overlap: din 1,1,0,1,1,0,1 → dout high after bits 4 and 7 only; match_cnt=2. Repeat with OVERLAP=0 → dout high after bit 4 only; state_o after bit 7 = 1; match_cnt=1.
3. Failure rule: din 1,1,1,0,1 → state_o 1,2,2,3,4; dout high after bit 5 only.
4. Qualification hold: complete the match, then din_valid=0 for 3 cycles with din toggling → dout stays 1 and state_o=4; match_cnt stays 1. Then din_valid=1 with din=0 → state_o=0, dout=0.
5. Async reset mid-pattern: after din 1,1,0, pulse areset_n low between edges → state_o=0 and dout=0 before the next edge. Then din 1 → state_o=1, no match.
6. clr priority and saturation:
   - With CNT_W=2, produce 5 matches → match_cnt=3.
   - Then assert clr with din_valid=1, din=1 in state 3 → next state_o=0, match_cnt=0, dout=0.
